adc_window_capture: RTL and testbench



---
 rtl/adc_cap_pkg.sv | 43 ++++
 rtl/adc_window_capture_record_fifo.sv | 73 +++++++
 rtl/adc_window_capture.sv | 179 +++++++++++++++++
 tb/tb_adc_window_capture.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_cap_pkg.sv
// Shared types and constants for the ADC window capture block.
package adc_cap_pkg;

  // Capture FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_QUIET  = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  // Serial frame geometry
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned DATA_BITS  = 12;

  // Record layout: {rot, ch, ch_err, count, sum}
  localparam int unsigned RECORD_W = 41;
  localparam int unsigned SUM_W    = 20;
  localparam int unsigned SUM_LSB  = 0;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned CNT_LSB  = 20;
  localparam int unsigned ERR_LSB  = 28;
  localparam int unsigned CH_W     = 2;
  localparam int unsigned CH_LSB   = 29;
  localparam int unsigned ROT_W    = 10;
  localparam int unsigned ROT_LSB  = 31;
  localparam int unsigned SW_W     = 4;

  // One-hot RF switch to {channel, error}; anything not one-hot is an error
  function automatic logic [CH_W:0] ch_encode(input logic [SW_W-1:0] sw);
    logic [CH_W:0] r;
    case (sw)
      4'b0001: r = {2'd0, 1'b0};
      4'b0010: r = {2'd1, 1'b0};
      4'b0100: r = {2'd2, 1'b0};
      4'b1000: r = {2'd3, 1'b0};
      default: r = {2'd0, 1'b1};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/adc_window_capture_record_fifo.sv
// First-word-fall-through record FIFO with sticky overflow and push+pop when full.
module record_fifo #(
  parameter int unsigned WIDTH = 41,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
  logic             do_pop, do_push;

  // Pointer, occupancy and storage update
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    do_pop  = pop & ~empty_q;
    do_push = push & (~full_q | do_pop);
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CW'(DEPTH));
    ovf_d   = ovf_q | (push & full_q & ~do_pop);
  end

  // FIFO state registers; contents are cleared so the head reads zero after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout     = mem_q[rd_q];
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/adc_window_capture.sv
// Runs back-to-back SPI ADC conversions per adc_en window and commits a tagged record.
module adc_window_capture
  import adc_cap_pkg::*;
#(
  parameter int unsigned SCLK_DIV   = 4,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned QUIET_CYC  = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                fpga_clk,
  input  logic                rst_n,
  input  logic                adc_en,
  input  logic [SW_W-1:0]     rf_sw,
  input  logic [ROT_W-1:0]    rot_count,
  input  logic                adc_sdo,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  input  logic                rd_en,
  output logic [RECORD_W-1:0] rd_data,
  output logic                fifo_empty,
  output logic                fifo_full,
  output logic                overflow
);

  localparam int unsigned PERIOD  = 2 * SCLK_DIV;
  localparam int unsigned TMR_MAX = (PERIOD > SETUP_CYC)
                                  ? ((PERIOD > QUIET_CYC) ? PERIOD : QUIET_CYC)
                                  : ((SETUP_CYC > QUIET_CYC) ? SETUP_CYC : QUIET_CYC);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);
  localparam int unsigned BIT_W   = $clog2(FRAME_BITS);

  state_e               state_q, state_d;
  logic                 en_q, en_d, pend_q, pend_d;
  logic [ROT_W-1:0]     rot_q, rot_d;
  logic [SW_W-1:0]      sw_q, sw_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 cs_n_q, cs_n_d, sclk_q, sclk_d;
  logic                 start_c, push_c;
  logic [CH_W:0]        ch_c;
  logic [RECORD_W-1:0]  rec_c;

  // Next-state, datapath and registered SPI pin values
  always_comb begin
    state_d = state_q;
    en_d    = adc_en;
    pend_d  = pend_q;
    rot_d   = rot_q;
    sw_d    = sw_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    push_c  = 1'b0;
    start_c = adc_en & ~en_q;

    // A window requested while busy is remembered and started after COMMIT
    if (start_c && (state_q != ST_IDLE)) pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start_c || pend_q) begin
          state_d = ST_SETUP;
          pend_d  = 1'b0;
          rot_d   = rot_count;
          sw_d    = rf_sw;
          sum_d   = '0;
          cnt_d   = '0;
          tmr_d   = '0;
        end
      end
      ST_SETUP: begin
        if (tmr_q == TMR_W'(SETUP_CYC - 1)) begin
          state_d = ST_SHIFT;
          tmr_d   = '0;
          bit_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_SHIFT: begin
        if (tmr_q == TMR_W'(SCLK_DIV - 1)) shreg_d = {shreg_q[DATA_BITS-2:0], adc_sdo};
        if (tmr_q == TMR_W'(PERIOD - 1)) begin
          tmr_d = '0;
          if (bit_q == BIT_W'(FRAME_BITS - 1)) state_d = ST_QUIET;
          else                                 bit_d   = bit_q + BIT_W'(1);
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_QUIET: begin
        // Leading frame bits have already fallen out of the 12-bit shifter
        if (tmr_q == '0) begin
          sum_d = sum_q + SUM_W'(shreg_q);
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        end
        if (tmr_q == TMR_W'(QUIET_CYC - 1)) begin
          tmr_d   = '0;
          state_d = adc_en ? ST_SETUP : ST_COMMIT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_COMMIT: begin
        push_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cs_n_d = ~((state_d == ST_SETUP) || (state_d == ST_SHIFT));
    sclk_d = ~((state_d == ST_SHIFT) && (tmr_d < TMR_W'(SCLK_DIV)));
  end

  // Record assembly from the latched window tags and accumulators
  always_comb begin
    ch_c                            = ch_encode(sw_q);
    rec_c                           = '0;
    rec_c[ROT_LSB +: ROT_W]         = rot_q;
    rec_c[CH_LSB +: CH_W]           = ch_c[CH_W:1];
    rec_c[ERR_LSB]                  = ch_c[0];
    rec_c[CNT_LSB +: CNT_W]         = cnt_q;
    rec_c[SUM_LSB +: SUM_W]         = sum_q;
  end

  // State and datapath registers; pins go idle-high immediately on reset
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
      rot_q   <= '0;
      sw_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
      tmr_q   <= '0;
      bit_q   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      rot_q   <= rot_d;
      sw_q    <= sw_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
    end
  end

  assign adc_cs_n = cs_n_q;
  assign adc_sclk = sclk_q;

  record_fifo #(
    .WIDTH (RECORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (fpga_clk),
    .rst_n    (rst_n),
    .push     (push_c),
    .din      (rec_c),
    .pop      (rd_en),
    .dout     (rd_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_adc_window_capture.sv
// Directed/randomized bench for adc_window_capture with an ADC model and a record-level reference.
module tb_adc_window_capture;

  logic        fpga_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adc_en = 1'b0;
  logic [3:0]  rf_sw = 4'd0;
  logic [9:0]  rot_count = 10'd0;
  logic        adc_sdo = 1'b0;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        rd_en = 1'b0;
  logic [40:0] rd_data;
  logic        fifo_empty, fifo_full, overflow;

  int vectors = 0;
  int miscompares = 0;

  adc_window_capture dut (
    .fpga_clk   (fpga_clk),
    .rst_n      (rst_n),
    .adc_en     (adc_en),
    .rf_sw      (rf_sw),
    .rot_count  (rot_count),
    .adc_sdo    (adc_sdo),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  always #5 fpga_clk = ~fpga_clk;

  // ADC model: per-window sample list, 16-bit frames driven MSB-first on sclk falls
  logic [11:0] win_data [8];
  int          win_base = 0;
  bit          mon_en = 1'b0;
  int          cs_falls = 0;
  int          falls = 0;
  int          frames = 0;
  int          bad_len = 0;
  int          bad_setup = 0;
  time         t_cs = 0;
  logic [15:0] frame = 16'd0;
  logic        cs_prev = 1'b1;
  logic        sclk_prev = 1'b1;

  always @(adc_cs_n, adc_sclk) begin
    if (mon_en) begin
      if (cs_prev === 1'b1 && adc_cs_n === 1'b0) begin
        int k;
        k = cs_falls - win_base;
        frame = {4'($urandom), (k >= 0 && k < 8) ? win_data[k] : 12'h000};
        cs_falls++;
        falls = 0;
        t_cs = $time;
      end else if (cs_prev === 1'b0 && adc_cs_n === 1'b1 && rst_n === 1'b1) begin
        frames++;
        if (falls != 16) bad_len++;
      end
      if (sclk_prev === 1'b1 && adc_sclk === 1'b0 && adc_cs_n === 1'b0) begin
        if (falls == 0 && ($time - t_cs) != 20) bad_setup++;
        if (falls < 16) adc_sdo = frame[15 - falls];
        falls++;
      end
    end
    cs_prev = adc_cs_n;
    sclk_prev = adc_sclk;
  end

  logic [40:0] exp_q [$];
  int          exp_frames = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record expected from the window's tags, conversion count and sample total
  function automatic logic [40:0] model(input logic [9:0] rot, input logic [3:0] sw,
                                        input int n, input logic [19:0] s);
    logic [1:0] ch;
    logic       err;
    int         c;
    ch = 2'd0;
    err = 1'b1;
    if ($countones(sw) == 1) begin
      err = 1'b0;
      for (int b = 0; b < 4; b++) if (sw[b]) ch = 2'(b);
    end
    c = (n > 255) ? 255 : n;
    return {rot, ch, err, 8'(c), s};
  endfunction

  // One acquisition window of n conversions; optionally pops on the COMMIT cycle
  task automatic window(input logic [3:0] sw, input logic [9:0] rot, input int n, input int len_in,
                        input bit fixed, input logic [11:0] fval, input bit store, input bit pop_commit);
    logic [19:0] s;
    logic [11:0] d;
    int          len;
    bit          seen;
    logic        prev;
    s = 20'd0;
    for (int i = 0; i < 8; i++) begin
      d = fixed ? fval : 12'($urandom);
      win_data[i] = (i < n) ? d : 12'hFFF;
      if (i < n) s = s + 20'(d);
    end
    win_base = cs_falls;
    len = (len_in > 0) ? len_in
        : ((n == 1) ? 1 + int'($urandom_range(0, 100)) : 134 * (n - 1) + int'($urandom_range(10, 120)));
    @(posedge fpga_clk); #1;
    rf_sw = sw; rot_count = rot; adc_en = 1'b1;
    @(posedge fpga_clk); #1;
    rot_count = 10'($urandom);
    repeat (len - 1) @(posedge fpga_clk);
    #1 adc_en = 1'b0;
    chk("empty_before_commit", 64'(fifo_empty), 64'(exp_q.size() == 0));
    if (pop_commit) begin
      seen = 1'b0;
      prev = adc_cs_n;
      for (int i = 0; i < 400 && !seen; i++) begin
        @(posedge fpga_clk); #1;
        if (prev === 1'b0 && adc_cs_n === 1'b1) seen = 1'b1;
        prev = adc_cs_n;
      end
      chk("commit_wait", 64'(seen), 64'd1);
      repeat (4) @(posedge fpga_clk);
      #1 rd_en = 1'b1;
      @(posedge fpga_clk);
      #1 rd_en = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      repeat (3) @(posedge fpga_clk);
    end else begin
      repeat (n * 134 + 6 - len) @(posedge fpga_clk);
    end
    #1;
    exp_frames += n;
    if (store) exp_q.push_back(model(rot, sw, n, s));
  endtask

  // Read out and compare every expected record, then confirm empty
  task automatic drain();
    for (int i = 0; i < 16 && exp_q.size() > 0; i++) begin
      chk("rd_data", 64'(rd_data), 64'(exp_q[0]));
      chk("not_empty", 64'(fifo_empty), 64'd0);
      rd_en = 1'b1;
      @(posedge fpga_clk);
      #1 rd_en = 1'b0;
      void'(exp_q.pop_front());
    end
    chk("drained_empty", 64'(fifo_empty), 64'd1);
  endtask

  function automatic logic [3:0] rand_sw();
    if ($urandom_range(0, 1) == 1) return 4'b0001 << $urandom_range(0, 3);
    return 4'($urandom);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #23;
    chk("rst_cs_n", 64'(adc_cs_n), 64'd1);
    chk("rst_sclk", 64'(adc_sclk), 64'd1);
    chk("rst_empty", 64'(fifo_empty), 64'd1);
    chk("rst_full", 64'(fifo_full), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    @(negedge fpga_clk) rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(posedge fpga_clk);

    // 300-cycle window of 12'h800 samples gives three conversions
    window(4'b1000, 10'd513, 3, 300, 1'b1, 12'h800, 1'b1, 1'b0);
    chk("t1_count", 64'(rd_data[27:20]), 64'd3);
    chk("t1_sum", 64'(rd_data[19:0]), 64'd6144);
    chk("t1_ch", 64'(rd_data[30:28]), 64'b110);
    drain();

    // Single-cycle pulse, tag latched at window start
    window(4'b0100, 10'd37, 1, 1, 1'b1, 12'hA5C, 1'b1, 1'b0);
    chk("t2_rot", 64'(rd_data[40:31]), 64'd37);
    chk("t2_ch", 64'(rd_data[30:28]), 64'b100);
    chk("t2_count", 64'(rd_data[27:20]), 64'd1);
    chk("t2_sum", 64'(rd_data[19:0]), 64'hA5C);
    drain();

    // Invalid switch states
    window(4'b0000, 10'($urandom), 1, 0, 1'b0, 12'h0, 1'b1, 1'b0);
    chk("t3_err0000", 64'(rd_data[30:28]), 64'b001);
    window(4'b0011, 10'($urandom), 1, 0, 1'b0, 12'h0, 1'b1, 1'b0);
    drain();

    // Randomized windows
    for (int i = 0; i < 6; i++) begin
      window(rand_sw(), 10'($urandom), int'($urandom_range(1, 3)), 0, 1'b0, 12'h0, 1'b1, 1'b0);
      drain();
    end
    chk("spi_frame_len", 64'(bad_len), 64'd0);
    chk("spi_setup_delay", 64'(bad_setup), 64'd0);
    chk("spi_frames", 64'(frames), 64'(exp_frames));

    // Fill, then overflow drops the ninth record
    for (int i = 0; i < 8; i++) window(rand_sw(), 10'($urandom), 1, 0, 1'b0, 12'h0, 1'b1, 1'b0);
    chk("fill_full", 64'(fifo_full), 64'd1);
    chk("fill_no_ovf", 64'(overflow), 64'd0);
    window(rand_sw(), 10'($urandom), 1, 0, 1'b0, 12'h0, 1'b0, 1'b0);
    chk("ovf_full", 64'(fifo_full), 64'd1);
    chk("ovf_set", 64'(overflow), 64'd1);
    drain();
    chk("ovf_sticky", 64'(overflow), 64'd1);

    @(negedge fpga_clk) rst_n = 1'b0;
    @(negedge fpga_clk) rst_n = 1'b1;
    #1;
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // Full FIFO with a read on the COMMIT cycle: push and pop both happen
    for (int i = 0; i < 8; i++) window(rand_sw(), 10'($urandom), 1, 0, 1'b0, 12'h0, 1'b1, 1'b0);
    window(rand_sw(), 10'($urandom), 1, 0, 1'b0, 12'h0, 1'b1, 1'b1);
    chk("pp_no_ovf", 64'(overflow), 64'd0);
    chk("pp_full", 64'(fifo_full), 64'd1);
    drain();
    chk("spi_frames2", 64'(frames), 64'(exp_frames));

    // Reset in the middle of a frame
    window(4'b0010, 10'd100, 1, 0, 1'b0, 12'h0, 1'b1, 1'b0);
    win_base = cs_falls;
    for (int i = 0; i < 8; i++) win_data[i] = 12'($urandom);
    @(posedge fpga_clk); #1;
    rf_sw = 4'b0001; rot_count = 10'd5; adc_en = 1'b1;
    repeat (5) @(posedge fpga_clk);
    @(negedge fpga_clk);
    chk("mid_sclk_low", 64'(adc_sclk), 64'd0);
    chk("mid_cs_low", 64'(adc_cs_n), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_cs_n", 64'(adc_cs_n), 64'd1);
    chk("arst_sclk", 64'(adc_sclk), 64'd1);
    chk("arst_empty", 64'(fifo_empty), 64'd1);
    exp_q.delete();
    adc_en = 1'b0;
    repeat (3) @(negedge fpga_clk);
    rst_n = 1'b1;
    window(4'b1000, 10'd777, 2, 0, 1'b0, 12'h0, 1'b1, 1'b0);
    drain();
    chk("spi_frame_len_end", 64'(bad_len), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
